arm_multicycle_ctrl: RTL
========================

Name: arm_multicycle_ctrl

Overview:
- Multicycle ARMv4-subset main controller. Replaces the single-cycle combinational main decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles on one shared memory port and ALU.
- Sits between the instruction register (Op/Funct fields) and the datapath mux/enable controls.
- Generalises the single-cycle design in three ways:
  - optional memory wait-state handshake;
  - illegal-opcode detection;
  - retired-instruction counter.

Parameters:
- MEM_HANDSHAKE, 0: 0 = memory completes in one cycle and mem_ready is ignored (treated as 1); 1 = FETCH/MEMREAD/MEMWRITE stall until mem_ready=1.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Op  in  2  instruction bits [27:26], held in the IR
- Funct  in  6  instruction bits [25:20]; Funct[5]=I (immediate), Funct[0]=S/L (load)
- mem_ready  in  1  memory access complete this cycle
- NextPC  out  1  PC write enable (fetch increment)
- Branch  out  1  branch PC write request, to conditional logic
- RegW  out  1  register-file write request
- MemW  out  1  data memory write
- IRWrite  out  1  instruction-register load
- AdrSrc  out  1  0 = PC, 1 = ALU result to memory address
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  1  0 = RD1, 1 = PC
- ALUSrcB  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4
- ALUOp  out  1  1 = ALU decoder uses Funct, 0 = add
- ImmSrc  out  2  00 = DP imm8, 01 = mem imm12, 10 = branch imm24
- RegSrc  out  2  register-address source select
- illegal_op  out  1  one-cycle pulse when Op=11 is decoded
- instr_done  out  1  one-cycle pulse when an instruction retires
- retired  out  CNT_W  count of retired instructions
- state  out  4  current state encoding (debug)

Behaviour:
- State register resets asynchronously to FETCH. While rst_n=0, all outputs are 0: the combinational enables NextPC, IRWrite, RegW, MemW and Branch are ANDed with rst_n, and retired=0.
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Encodings 10-15 return to FETCH on the next edge with all outputs 0.
- Unlisted outputs are 0 in each state below. "rdy" means mem_ready, or constant 1 when MEM_HANDSHAKE=0.
- FETCH:
  - AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10.
  - IRWrite=rdy and NextPC=rdy, so the PC advances exactly once per fetch.
  - Next state: DECODE if rdy, else stay in FETCH.
- DECODE:
  - ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - Op=00, Funct[5]=0 -> EXECR. Op=00, Funct[5]=1 -> EXECI.
  - Op=01 -> MEMADR. Op=10 -> BRANCH.
  - Op=11 -> FETCH, with illegal_op=1 and instr_done=1 in that cycle.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0. Next state: MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next state: MEMWB if rdy, else stay.
- MEMWB: ResultSrc=01, RegW=1, instr_done=1. Next state: FETCH.
- MEMWRITE:
  - AdrSrc=1, ResultSrc=00, MemW=1, held for the whole stall.
  - instr_done=rdy.
  - Next state: FETCH if rdy, else stay.
- EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1. Next state: ALUWB.
- EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. Next state: ALUWB.
- ALUWB: ResultSrc=00, RegW=1, instr_done=1. Next state: FETCH.
- BRANCH:
  - ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10.
  - Branch=1, instr_done=1.
  - Next state: FETCH.
- ImmSrc/RegSrc are combinational from Op/Funct in every state:
  - Op=00: ImmSrc=00, RegSrc=00.
  - Op=01: ImmSrc=01, RegSrc = 10 if Funct[0]=0 (store), else 00.
  - Op=10: ImmSrc=10, RegSrc=01.
  - Op=11: ImmSrc=00, RegSrc=00.
- Counter: retired increments by 1 on every clock edge where instr_done=1, and wraps from 2^CNT_W-1 to 0.
- Cycle counts with zero wait states:
  - DP: 4 cycles (FETCH, DECODE, EXEC, ALUWB).
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
  - Illegal opcode: 2 cycles.
  - Each mem_ready=0 cycle adds one.
- Reset mid-instruction: returns immediately to FETCH. Any stalled MemW/IRWrite drops asynchronously. The counter clears.

Test Plan:
- Reset: rst_n=0 mid-MEMWRITE stall -> MemW drops to 0 immediately, state=0, retired=0; after release, first edge sees IRWrite=NextPC=1.
- ADD reg (Op=00, Funct=000000), MEM_HANDSHAKE=0 -> state 0,1,6,8; RegW=1 only in the cycle of state 8; instr_done pulses once; retired=1.
- LDR (Op=01, Funct[0]=1), MEM_HANDSHAKE=1, mem_ready low 2 cycles in FETCH and 3 cycles in MEMREAD -> NextPC asserted exactly once; state sequence 0,0,0,1,2,3,3,3,3,4; ImmSrc=01, RegSrc=00.
- STR (Op=01, Funct[0]=0), mem_ready=0 for 2 cycles -> MemW high 3 consecutive cycles, RegSrc=10, no RegW, instr_done only on the accepted cycle.
- B (Op=10), then Op=11 -> branch: states 0,1,9 with Branch=1, ImmSrc=10, RegSrc=01; illegal: states 0,1 with illegal_op=1, no write enable, retired increments by 2 in total.
- CNT_W=4: issue 17 branches -> retired wraps 15 to 0 and reads 1 at the end.

Source files
------------

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARMv4-subset main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback
// over a shared memory port, with optional memory wait states, illegal-opcode flag and retire counter.
module arm_multicycle_ctrl #(
    parameter bit          MEM_HANDSHAKE = 1'b0,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             mem_ready,
    output logic             NextPC,
    output logic             Branch,
    output logic             RegW,
    output logic             MemW,
    output logic             IRWrite,
    output logic             AdrSrc,
    output logic [1:0]       ResultSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             ALUOp,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       RegSrc,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t cur_state, nxt_state;

    logic       rdy;
    logic       next_pc_c, branch_c, reg_w_c, mem_w_c, ir_write_c, adr_src_c;
    logic       alu_src_a_c, alu_op_c, illegal_c, done_c, valid_c;
    logic [1:0] result_src_c, alu_src_b_c, imm_src_c, reg_src_c;
    logic       unused_funct;

    // Without the handshake every memory access completes in one cycle
    assign rdy          = mem_ready | ~MEM_HANDSHAKE;
    assign unused_funct = ^Funct[4:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state    = cur_state;
        next_pc_c    = 1'b0;
        branch_c     = 1'b0;
        reg_w_c      = 1'b0;
        mem_w_c      = 1'b0;
        ir_write_c   = 1'b0;
        adr_src_c    = 1'b0;
        result_src_c = 2'b00;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'b00;
        alu_op_c     = 1'b0;
        illegal_c    = 1'b0;
        done_c       = 1'b0;
        valid_c      = 1'b1;
        imm_src_c    = 2'b00;
        reg_src_c    = 2'b00;

        case (cur_state)
            S_FETCH: begin
                alu_src_a_c  = 1'b1;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                ir_write_c   = rdy;
                next_pc_c    = rdy;
                nxt_state    = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a_c  = 1'b1;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                case (Op)
                    2'b00:   nxt_state = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   nxt_state = S_MEMADR;
                    2'b10:   nxt_state = S_BRANCH;
                    default: begin
                        nxt_state = S_FETCH;
                        illegal_c = 1'b1;
                        done_c    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_b_c = 2'b01;
                nxt_state   = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src_c = 1'b1;
                nxt_state = rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_w_c      = 1'b1;
                done_c       = 1'b1;
                nxt_state    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_c = 1'b1;
                mem_w_c   = 1'b1;
                done_c    = rdy;
                nxt_state = rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_op_c  = 1'b1;
                nxt_state = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_b_c = 2'b01;
                alu_op_c    = 1'b1;
                nxt_state   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w_c   = 1'b1;
                done_c    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b_c  = 2'b01;
                result_src_c = 2'b10;
                branch_c     = 1'b1;
                done_c       = 1'b1;
                nxt_state    = S_FETCH;
            end
            default: begin
                valid_c   = 1'b0;
                nxt_state = S_FETCH;
            end
        endcase

        // Immediate/register-address selects follow the IR fields in every legal state
        if (valid_c) begin
            case (Op)
                2'b01: begin
                    imm_src_c = 2'b01;
                    reg_src_c = Funct[0] ? 2'b00 : 2'b10;
                end
                2'b10: begin
                    imm_src_c = 2'b10;
                    reg_src_c = 2'b01;
                end
                default: begin
                    imm_src_c = 2'b00;
                    reg_src_c = 2'b00;
                end
            endcase
        end
    end

    // Everything is forced low while reset is held, so a stalled write drops at once
    assign NextPC     = next_pc_c & rst_n;
    assign Branch     = branch_c & rst_n;
    assign RegW       = reg_w_c & rst_n;
    assign MemW       = mem_w_c & rst_n;
    assign IRWrite    = ir_write_c & rst_n;
    assign AdrSrc     = adr_src_c & rst_n;
    assign ResultSrc  = result_src_c & {2{rst_n}};
    assign ALUSrcA    = alu_src_a_c & rst_n;
    assign ALUSrcB    = alu_src_b_c & {2{rst_n}};
    assign ALUOp      = alu_op_c & rst_n;
    assign ImmSrc     = imm_src_c & {2{rst_n}};
    assign RegSrc     = reg_src_c & {2{rst_n}};
    assign illegal_op = illegal_c & rst_n;
    assign instr_done = done_c & rst_n;
    assign state      = 4'(cur_state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (done_c) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule
